// File: rtl/cska_pkg.sv
// Shared elaboration helpers for the pipelined carry-skip adder: block counts
// and the parameter-legality rule.
package cska_pkg;

   function automatic int num_blocks(input int width, input int block);
      return (block < 1) ? 0 : width / block;
   endfunction

   function automatic int blocks_per_stage(input int width, input int block, input int stages);
      return (stages < 1) ? 0 : num_blocks(width, block) / stages;
   endfunction

   function automatic bit params_legal(input int width, input int block, input int stages);
      if (width < 1 || block < 1 || stages < 1) return 1'b0;
      return (width % block == 0) && (num_blocks(width, block) % stages == 0);
   endfunction

endpackage

// File: rtl/cska_stage.sv
// One pipeline slice: BPS carry-skip blocks starting at stage IDX, plus the
// register slice and valid bit that hold the partially summed operation.
module cska_stage #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4,
   parameter int BPS   = 4,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic             adv_i,
   output logic             adv_c,
   output logic             valid_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] sum_i,
   input  logic             c_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             c_o,
   output logic             sub_o,
   output logic             ovf_o
);

   localparam int LO = IDX * BPS * BLOCK;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             c_q, c_d, sub_q, sub_d, ovf_q, ovf_d;
   logic [WIDTH-1:0] sum_c;
   logic             carry_c, rc, prop, x;
   logic [IW-1:0]    idx;
   logic             ovf_c;

   // Ripple each block; skip with the XOR propagate so a skip never bypasses a generate.
   always_comb begin
      sum_c   = sum_i;
      carry_c = c_i;
      rc      = 1'b0;
      prop    = 1'b0;
      x       = 1'b0;
      idx     = '0;
      for (int j = 0; j < BPS; j++) begin
         rc   = carry_c;
         prop = 1'b1;
         for (int t = 0; t < BLOCK; t++) begin
            idx        = IW'(LO + j * BLOCK + t);
            x          = a_i[idx] ^ b_i[idx];
            sum_c[idx] = x ^ rc;
            rc         = (a_i[idx] & b_i[idx]) | (rc & x);
            prop       = prop & x;
         end
         carry_c = prop ? carry_c : rc;
      end
      ovf_c = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]);
   end

   assign adv_c = !valid_q || adv_i;

   // Load the slice whenever it advances; otherwise hold it.
   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      c_d     = c_q;
      sub_d   = sub_q;
      ovf_d   = ovf_q;
      if (adv_c) begin
         valid_d = valid_i;
         a_d     = a_i;
         b_d     = b_i;
         sum_d   = sum_c;
         c_d     = carry_c;
         sub_d   = sub_i;
         ovf_d   = ovf_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
         sub_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         c_q     <= c_d;
         sub_q   <= sub_d;
         ovf_q   <= ovf_d;
      end
   end

   assign valid_o = valid_q;
   assign a_o     = a_q;
   assign b_o     = b_q;
   assign sum_o   = sum_q;
   assign c_o     = c_q;
   assign sub_o   = sub_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Valid/ready pipelined carry-skip adder/subtractor; each of STAGES slices
// resolves BLOCKS_PER_STAGE skip blocks of the running sum.
module pipelined_carry_skip_adder
   import cska_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NUM_BLOCKS       = num_blocks(WIDTH, BLOCK);
   localparam int BLOCKS_PER_STAGE = blocks_per_stage(WIDTH, BLOCK, STAGES);

   // Index k is the payload entering stage k; index STAGES is the output slice.
   logic             v_p   [STAGES+1];
   logic             rdy_p [STAGES+1];
   logic [WIDTH-1:0] a_p   [STAGES+1];
   logic [WIDTH-1:0] b_p   [STAGES+1];
   logic [WIDTH-1:0] sum_p [STAGES+1];
   logic             c_p   [STAGES+1];
   logic             sub_p [STAGES+1];
   logic             ovf_p [STAGES];

   // Subtraction enters as a + ~b + 1, so cin is dropped when sub is set.
   assign v_p[0]        = in_valid;
   assign a_p[0]        = a;
   assign b_p[0]        = sub ? ~b : b;
   assign sum_p[0]      = '0;
   assign c_p[0]        = sub | cin;
   assign sub_p[0]      = sub;
   assign rdy_p[STAGES] = out_ready;

   if (!params_legal(WIDTH, BLOCK, STAGES) || (BLOCKS_PER_STAGE * STAGES != NUM_BLOCKS)) begin : g_bad_params
      $fatal(1, "pipelined_carry_skip_adder: illegal WIDTH/BLOCK/STAGES");
   end else begin : g_pipe
      for (genvar g = 0; g < STAGES; g++) begin : g_stage
         cska_stage #(
            .WIDTH (WIDTH),
            .BLOCK (BLOCK),
            .BPS   (BLOCKS_PER_STAGE),
            .IDX   (g)
         ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (v_p[g]),
            .adv_i   (rdy_p[g+1]),
            .adv_c   (rdy_p[g]),
            .valid_o (v_p[g+1]),
            .a_i     (a_p[g]),
            .b_i     (b_p[g]),
            .sum_i   (sum_p[g]),
            .c_i     (c_p[g]),
            .sub_i   (sub_p[g]),
            .a_o     (a_p[g+1]),
            .b_o     (b_p[g+1]),
            .sum_o   (sum_p[g+1]),
            .c_o     (c_p[g+1]),
            .sub_o   (sub_p[g+1]),
            .ovf_o   (ovf_p[g])
         );
      end
   end

   assign in_ready  = rdy_p[0];
   assign out_valid = v_p[STAGES];
   assign sum       = sum_p[STAGES];
   assign cout      = c_p[STAGES];
   assign overflow  = ovf_p[STAGES-1];

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Randomized and directed bench for the pipelined carry-skip adder, scored
// against an arithmetic reference through an in-order expectation queue.
module tb_pipelined_carry_skip_adder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic         cin, sub, cout, overflow;
   logic [W-1:0] a, b, sum;

   int n_vec = 0;
   int n_err = 0;
   int n_out = 0;
   logic [W+1:0] exp_q [$];

   always #5 clk = ~clk;

   pipelined_carry_skip_adder #(.WIDTH(W), .BLOCK(4), .STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // {overflow, cout, sum} from plain integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic s);
      int         sx, sy, r;
      logic [W:0] u;
      logic       ov;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (s) begin
         u = (W+1)'({1'b0, x} + 17'h10000 - {1'b0, y});
         r = sx - sy;
      end else begin
         u = {1'b0, x} + {1'b0, y} + {16'b0, ci};
         r = sx + sy + int'(ci);
      end
      ov = (r > 32767) || (r < -32768);
      return {ov, u};
   endfunction

   task automatic new_op();
      int m;
      m   = int'($urandom_range(0, 3));
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      if (m == 1) b = ~a;
      if (m == 2) a = 16'hFFFF;
   endtask

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   initial begin : monitor
      logic         stall_prev;
      logic [W+1:0] held, e;
      stall_prev = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("hold_valid", 32'(out_valid), 32'd1);
               chk("hold_data", 32'({overflow, cout, sum}), 32'(held));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_out", 32'(out_valid), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("result", 32'({overflow, cout, sum}), 32'(e));
                  n_out++;
               end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            stall_prev = out_valid && !out_ready;
            held       = {overflow, cout, sum};
         end
      end
   end

   task automatic one_shot(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tci,
                           input logic tsub, input logic [W-1:0] esum, input logic ecout,
                           input logic eovf, input string tag);
      a = ta; b = tb2; cin = tci; sub = tsub; in_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"}, 32'(sum), 32'(esum));
      chk({tag, "_cout"}, 32'(cout), 32'(ecout));
      chk({tag, "_ovf"}, 32'(overflow), 32'(eovf));
      @(posedge clk); #1;
   endtask

   initial begin : main
      int   acc, outs, base, cyc;
      logic took;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #23;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;

      one_shot(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "skip_chain");
      one_shot(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
      one_shot(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
      one_shot(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
      one_shot(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "gen_cin");
      one_shot(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_cin_ign");

      // Backpressure: two operations fill the pipe, then in_ready drops.
      out_ready = 1'b0; acc = 0;
      new_op(); in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took) begin acc++; new_op(); end
      end
      in_valid = 1'b0;
      chk("stall_accepted", 32'(acc), 32'd2);
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      repeat (2) @(posedge clk);
      #1; base = n_out; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("stall_drained", 32'(n_out - base), 32'd2);
      chk("stall_q_empty", 32'(exp_q.size()), 32'd0);

      // Reset with both stages full: nothing may emerge afterwards.
      out_ready = 1'b0; new_op(); in_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; new_op(); end
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_full", 32'(out_valid), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async_out_valid", 32'(out_valid), 32'd0);
      chk("rst_async_in_ready", 32'(in_ready), 32'd1);
      chk("rst_async_sum", 32'(sum), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1; new_op(); in_valid = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("post_rst_first", 32'(out_valid), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

      // Full throughput with out_ready held high.
      acc = 0; outs = 0; new_op(); in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); took = in_valid && in_ready;
         if (i >= 2 && out_valid) outs++;
         @(posedge clk); #1;
         if (took) begin acc++; new_op(); end
      end
      in_valid = 1'b0;
      chk("thru_in", 32'(acc), 32'd200);
      chk("thru_out", 32'(outs), 32'd198);
      repeat (4) @(posedge clk);
      #1;

      // 1000 random operations with random valid and out_ready.
      acc = 0; cyc = 0; new_op(); in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      while (acc < 1000 && cyc < 20000) begin
         @(negedge clk); took = in_valid && in_ready;
         @(posedge clk); #1;
         cyc++;
         if (took) begin acc++; new_op(); end
         if (took || !in_valid) in_valid = ($urandom_range(0, 3) != 0) && (acc < 1000);
         out_ready = ($urandom_range(0, 2) != 0);
      end
      in_valid = 1'b0;
      chk("rand_accepted", 32'(acc), 32'd1000);
      out_ready = 1'b1; cyc = 0;
      while (exp_q.size() != 0 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("final_drain", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
